// File: rtl/traffic_pkg.sv
// Shared encodings for the N-phase traffic light controller:
// lamp codes per approach and the controller state enumeration.
package traffic_pkg;

    localparam logic [1:0] L_R = 2'b00;
    localparam logic [1:0] L_G = 2'b01;
    localparam logic [1:0] L_Y = 2'b10;

    typedef enum logic [1:0] {
        ST_GREEN  = 2'd0,
        ST_YELLOW = 2'd1,
        ST_ALLRED = 2'd2
    } state_t;

endpackage

// File: rtl/traffic_rr_pick.sv
// Combinational round-robin pick: first set request after i_cur,
// searching i_cur+1, i_cur+2, ... modulo N_PHASE (i_cur itself last).
module traffic_rr_pick #(
    parameter int N_PHASE = 2,
    parameter int PH_W    = $clog2(N_PHASE)
) (
    input  logic [N_PHASE-1:0] i_req,
    input  logic [PH_W-1:0]    i_cur,
    output logic [PH_W-1:0]    o_next,
    output logic               o_found
);

    // Walk offsets from far to near so the nearest requester wins.
    always_comb begin
        o_next  = '0;
        o_found = 1'b0;
        for (int k = N_PHASE; k >= 1; k--) begin
            int idx;
            idx = (int'(i_cur) + k) % N_PHASE;
            if (i_req[idx]) begin
                o_next  = PH_W'(idx);
                o_found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_ctrl_n.sv
// N-phase traffic light controller: round-robin green with min/max dwell,
// yellow and all-red clearance intervals, and a latched hold mode.
module traffic_ctrl_n
    import traffic_pkg::*;
#(
    parameter int N_PHASE     = 2,
    parameter int PH_W        = $clog2(N_PHASE),
    parameter int CNT_W       = 8,
    parameter int T_MIN_GREEN = 10,
    parameter int T_MAX_GREEN = 30,
    parameter int T_YELLOW    = 4,
    parameter int T_ALLRED    = 2
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [N_PHASE-1:0]     i_traffic,
    input  logic                   i_hold_set,
    input  logic                   i_hold_clr,
    output logic [2*N_PHASE-1:0]   o_light,
    output logic [PH_W-1:0]        o_phase,
    output logic [1:0]             o_state,
    output logic                   o_hold
);

    localparam logic [CNT_W-1:0] MIN_LIM = CNT_W'(T_MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_LIM = CNT_W'(T_MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] Y_LIM   = CNT_W'(T_YELLOW - 1);
    localparam logic [CNT_W-1:0] AR_LIM  = CNT_W'(T_ALLRED - 1);

    state_t              r_state;
    logic [PH_W-1:0]     r_phase;
    logic [PH_W-1:0]     r_next_phase;
    logic [CNT_W-1:0]    r_timer;
    logic                r_hold;

    state_t              w_state_nxt;
    logic [PH_W-1:0]     w_phase_nxt;
    logic [PH_W-1:0]     w_next_phase_nxt;
    logic [CNT_W-1:0]    w_timer_nxt;
    logic [N_PHASE-1:0]  w_own_mask;
    logic                w_other_req;
    logic                w_own_req;
    logic                w_min_ok;
    logic                w_max_hit;
    logic                w_go_yellow;
    logic [PH_W-1:0]     w_pick;
    logic                w_pick_found;

    traffic_rr_pick #(
        .N_PHASE (N_PHASE),
        .PH_W    (PH_W)
    ) u_pick (
        .i_req   (i_traffic),
        .i_cur   (r_phase),
        .o_next  (w_pick),
        .o_found (w_pick_found)
    );

    assign w_own_mask  = {{(N_PHASE-1){1'b0}}, 1'b1} << r_phase;
    assign w_other_req = |(i_traffic & ~w_own_mask);
    assign w_own_req   = |(i_traffic & w_own_mask);
    assign w_min_ok    = (r_timer >= MIN_LIM);
    assign w_max_hit   = (r_timer >= MAX_LIM);
    // A waiting rival ends green once min dwell is met, unless our own
    // traffic keeps it going up to max dwell. Hold freezes green.
    assign w_go_yellow = w_min_ok && !r_hold && w_other_req && w_pick_found &&
                         (!w_own_req || w_max_hit);

    always_comb begin
        w_state_nxt      = r_state;
        w_phase_nxt      = r_phase;
        w_next_phase_nxt = r_next_phase;
        case (r_state)
            ST_GREEN: begin
                if (w_go_yellow) begin
                    w_state_nxt      = ST_YELLOW;
                    w_next_phase_nxt = w_pick;
                end
            end
            ST_YELLOW: begin
                if (r_timer == Y_LIM) w_state_nxt = ST_ALLRED;
            end
            ST_ALLRED: begin
                if (r_timer == AR_LIM) begin
                    w_state_nxt = ST_GREEN;
                    w_phase_nxt = r_next_phase;
                end
            end
            default: w_state_nxt = ST_GREEN;
        endcase
    end

    always_comb begin
        if (w_state_nxt != r_state) begin
            w_timer_nxt = '0;
        end else if (r_timer < MAX_LIM) begin
            w_timer_nxt = r_timer + 1'b1;
        end else begin
            w_timer_nxt = r_timer;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_GREEN;
            r_phase      <= '0;
            r_next_phase <= '0;
            r_timer      <= '0;
            r_hold       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_phase      <= w_phase_nxt;
            r_next_phase <= w_next_phase_nxt;
            r_timer      <= w_timer_nxt;
            if (i_hold_clr) begin
                r_hold <= 1'b0;
            end else if (i_hold_set) begin
                r_hold <= 1'b1;
            end
        end
    end

    always_comb begin
        o_light = '0;
        case (r_state)
            ST_GREEN:  o_light[2*int'(r_phase) +: 2] = L_G;
            ST_YELLOW: o_light[2*int'(r_phase) +: 2] = L_Y;
            default:   o_light = '0;
        endcase
    end

    assign o_phase = r_phase;
    assign o_state = r_state;
    assign o_hold  = r_hold;

endmodule
